// File: rtl/pipe_scroller_if.sv
// Bundle between the world generator and the display/collision side.
// Control pulses come in, and the registered world words go out.
// The master modport is the generator's view; the slave modport is the consumer's view.
interface pipe_scroller_if;
  logic        frame_tick;
  logic        start;
  logic        hit;
  logic        coin_hit;
  logic [31:0] pipe_1;
  logic [31:0] pipe_2;
  logic [31:0] pipe_3;
  logic [31:0] coin;
  logic [15:0] score;
  logic        pass_pulse;
  logic [1:0]  state;

  modport master (
    input  frame_tick, start, hit, coin_hit,
    output pipe_1, pipe_2, pipe_3, coin, score, pass_pulse, state
  );

  modport slave (
    output frame_tick, start, hit, coin_hit,
    input  pipe_1, pipe_2, pipe_3, coin, score, pass_pulse, state
  );
endinterface

// File: rtl/pipe_scroller.sv
// Game-world generator: three scrolling pipe slots, one coin, LFSR respawn and a BCD score.
// Latency: every output is registered and reflects the input pulses from the previous clk edge.
// Backpressure: none; the block accepts one set of control pulses every cycle.
module pipe_scroller #(
  parameter int          STEP     = 2,
  parameter int          SPACING  = 240,
  parameter int          PIPE_W   = 50,
  parameter int          BIRD_X   = 40,
  parameter int          H_MIN    = 80,
  parameter int          GAP_BASE = 120,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic            clk,
  input  logic            clrn,
  pipe_scroller_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_FREEZE = 2'b10;

  localparam logic signed [11:0] C_STEP     = 12'(STEP);
  localparam logic signed [11:0] C_PASS     = 12'(BIRD_X - PIPE_W);
  localparam logic signed [11:0] C_RESP     = 12'(-PIPE_W);
  localparam logic signed [11:0] C_WRAP     = 12'(3 * SPACING);
  localparam logic signed [11:0] C_COIN_OFF = 12'(PIPE_W / 2 - 8);
  localparam logic signed [11:0] C_COIN_MIN = -12'sd16;
  localparam logic signed [11:0] C_XMAX     = 12'sd640;

  // Visible x field: low 10 bits while on screen (wraps for a partly off-left sprite), else parked.
  function automatic logic [9:0] f_xfield(input logic signed [11:0] p, input logic signed [11:0] lo);
    return (p > lo && p < C_XMAX) ? p[9:0] : 10'd640;
  endfunction

  // Four-digit BCD add of 0..2 with ripple carry; an overflow out of the top digit sticks at 9999.
  function automatic logic [15:0] f_bcd_add(input logic [15:0] s, input logic [1:0] inc);
    logic [15:0] res;
    logic [4:0]  d;
    logic [1:0]  c;
    res = s;
    c   = inc;
    for (int k = 0; k < 4; k++) begin
      d = {1'b0, s[4*k +: 4]} + {3'b000, c};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 2'd1;
      end else begin
        c = 2'd0;
      end
      res[4*k +: 4] = d[3:0];
    end
    if (c != 2'd0) res = 16'h9999;
    return res;
  endfunction

  logic [1:0]         r_state, w_state;
  logic signed [11:0] r_pos [3];
  logic signed [11:0] w_pos [3];
  logic [9:0]         r_h [3];
  logic [9:0]         w_h [3];
  logic [7:0]         r_g [3];
  logic [7:0]         w_g [3];
  logic               r_coin_act, w_coin_act;
  logic signed [11:0] r_cx, w_cx;
  logic [9:0]         r_cy, w_cy;
  logic [15:0]        r_score, w_score;
  logic               r_pass, w_pass;
  logic               w_cv;
  logic signed [11:0] w_new;
  logic [15:0]        r_lfsr;
  logic               w_fb;
  logic [31:0]        r_pipe [3];
  logic [31:0]        w_pipe [3];
  logic [31:0]        r_coin, w_coin;
  logic               w_vis;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Next world state: start reinitialises, hit freezes, frame_tick scrolls, pass scores, respawns draw from the LFSR.
  always_comb begin
    w_state    = r_state;
    w_pos      = r_pos;
    w_h        = r_h;
    w_g        = r_g;
    w_coin_act = r_coin_act;
    w_cx       = r_cx;
    w_cy       = r_cy;
    w_score    = r_score;
    w_pass     = 1'b0;
    w_cv       = 1'b0;
    w_new      = '0;
    if (bus.start) begin
      w_state    = S_RUN;
      w_pos[0]   = 12'sd640;
      w_pos[1]   = 12'sd880;
      w_pos[2]   = 12'sd1120;
      w_h[0]     = 10'd200;
      w_h[1]     = 10'd160;
      w_h[2]     = 10'd240;
      w_g[0]     = 8'd140;
      w_g[1]     = 8'd140;
      w_g[2]     = 8'd140;
      w_coin_act = 1'b0;
      w_cx       = '0;
      w_cy       = '0;
      w_score    = '0;
    end else if (r_state == S_RUN) begin
      if (bus.hit) begin
        w_state = S_FREEZE;
      end else begin
        // A collected coin retires now, which also blocks a spawn in the same cycle.
        w_cv = bus.coin_hit && r_coin_act;
        if (w_cv) w_coin_act = 1'b0;
        if (bus.frame_tick) begin
          for (int i = 0; i < 3; i++) begin
            w_new = r_pos[i] - C_STEP;
            if (r_pos[i] > C_PASS && w_new <= C_PASS) w_pass = 1'b1;
            if (w_new <= C_RESP) begin
              w_new  = w_new + C_WRAP;
              w_h[i] = 10'(H_MIN) + {2'b00, r_lfsr[7:0]};
              w_g[i] = 8'(GAP_BASE) + {2'b00, r_lfsr[10:8], 3'b000};
              if (!r_coin_act && r_lfsr[15]) begin
                w_coin_act = 1'b1;
                w_cx       = w_new + C_COIN_OFF;
                w_cy       = w_h[i] + {3'b000, w_g[i][7:1]} - 10'd8;
              end
            end
            w_pos[i] = w_new;
          end
          if (r_coin_act && !w_cv) begin
            w_cx = r_cx - C_STEP;
            if (w_cx <= C_COIN_MIN) w_coin_act = 1'b0;
          end
        end
        w_score = f_bcd_add(r_score, {1'b0, w_pass} + {1'b0, w_cv});
      end
    end
  end

  // Pack next-state values into the display words so the outputs register on the same edge.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_pipe[i] = {4'b0000, w_g[i], f_xfield(w_pos[i], C_RESP), w_h[i]};
    end
    w_vis  = w_coin_act && (w_cx > C_COIN_MIN) && (w_cx < C_XMAX);
    w_coin = {w_vis, 11'b0, w_cy, f_xfield(w_cx, C_COIN_MIN)};
  end

  // World state, LFSR and output words; LFSR runs every cycle and reloads only on reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= S_IDLE;
      r_pos[0]   <= 12'sd640;
      r_pos[1]   <= 12'sd880;
      r_pos[2]   <= 12'sd1120;
      r_h[0]     <= 10'd200;
      r_h[1]     <= 10'd160;
      r_h[2]     <= 10'd240;
      r_g[0]     <= 8'd140;
      r_g[1]     <= 8'd140;
      r_g[2]     <= 8'd140;
      r_coin_act <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_score    <= '0;
      r_pass     <= 1'b0;
      r_lfsr     <= SEED;
      r_pipe[0]  <= 32'h08CA00C8;
      r_pipe[1]  <= 32'h08CA00A0;
      r_pipe[2]  <= 32'h08CA00F0;
      r_coin     <= '0;
    end else begin
      r_state    <= w_state;
      r_pos      <= w_pos;
      r_h        <= w_h;
      r_g        <= w_g;
      r_coin_act <= w_coin_act;
      r_cx       <= w_cx;
      r_cy       <= w_cy;
      r_score    <= w_score;
      r_pass     <= w_pass;
      r_lfsr     <= {r_lfsr[14:0], w_fb};
      r_pipe     <= w_pipe;
      r_coin     <= w_coin;
    end
  end

  assign bus.pipe_1     = r_pipe[0];
  assign bus.pipe_2     = r_pipe[1];
  assign bus.pipe_3     = r_pipe[2];
  assign bus.coin       = r_coin;
  assign bus.score      = r_score;
  assign bus.pass_pulse = r_pass;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomised bench for pipe_scroller with a queue-based scoreboard.
// The driver steps an integer world model each cycle and pushes the expected output words;
// the monitor pops one entry per clock and compares every output field.
module tb_pipe_scroller;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic clrn;
  pipe_scroller_if bus ();

  pipe_scroller dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p1, p2, p3, coin;
    logic [15:0] score;
    logic        pass;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference world in plain integers
  int          m_pos[3];
  int          m_h[3];
  int          m_g[3];
  int          m_cx, m_cy, m_score, m_state;
  bit          m_act, m_pass;
  logic [15:0] m_lfsr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [9:0] xf(input int p, input int lo);
    logic [31:0] v;
    v = p;
    return (p > lo && p < 640) ? v[9:0] : 10'd640;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic m_reinit();
    m_pos   = '{640, 880, 1120};
    m_h     = '{200, 160, 240};
    m_g     = '{140, 140, 140};
    m_act   = 0;
    m_cx    = 0;
    m_cy    = 0;
    m_score = 0;
    m_pass  = 0;
  endtask

  task automatic m_reset();
    m_reinit();
    m_state = 0;
    m_lfsr  = SEED;
  endtask

  task automatic m_step(input bit s, input bit h, input bit t, input bit ch);
    bit was, cv;
    int inc, np;
    m_pass = 0;
    if (s) begin
      m_reinit();
      m_state = 1;
    end else if (m_state == 1) begin
      if (h) begin
        m_state = 2;
      end else begin
        was = m_act;
        cv  = ch && m_act;
        inc = 0;
        if (cv) begin
          m_act = 0;
          inc   = 1;
        end
        if (t) begin
          for (int i = 0; i < 3; i++) begin
            np = m_pos[i] - 2;
            if (m_pos[i] > -10 && np <= -10) m_pass = 1;
            if (np <= -50) begin
              np     = np + 720;
              m_h[i] = 80 + int'(m_lfsr[7:0]);
              m_g[i] = 120 + 8 * int'(m_lfsr[10:8]);
              if (!was && m_lfsr[15]) begin
                m_act = 1;
                m_cx  = np + 17;
                m_cy  = m_h[i] + m_g[i] / 2 - 8;
              end
            end
            m_pos[i] = np;
          end
          if (was && !cv) begin
            m_cx = m_cx - 2;
            if (m_cx <= -16) m_act = 0;
          end
        end
        if (m_pass) inc++;
        m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
      end
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  function automatic exp_t m_expect();
    exp_t e;
    bit   vis;
    e.p1    = {4'b0, 8'(m_g[0]), xf(m_pos[0], -50), 10'(m_h[0])};
    e.p2    = {4'b0, 8'(m_g[1]), xf(m_pos[1], -50), 10'(m_h[1])};
    e.p3    = {4'b0, 8'(m_g[2]), xf(m_pos[2], -50), 10'(m_h[2])};
    vis     = m_act && m_cx > -16 && m_cx < 640;
    e.coin  = {vis, 11'b0, 10'(m_cy), xf(m_cx, -16)};
    e.score = to_bcd(m_score);
    e.pass  = m_pass;
    e.st    = 2'(m_state);
    return e;
  endfunction

  // One stimulus cycle: drive at the falling edge, advance the model, queue the expectation.
  task automatic cyc(input logic rn, input logic s, input logic h, input logic t, input logic ch);
    @(negedge clk);
    clrn           = rn;
    bus.start      = s;
    bus.hit        = h;
    bus.frame_tick = t;
    bus.coin_hit   = ch;
    if (!rn) m_reset();
    else     m_step(s, h, t, ch);
    exp_q.push_back(m_expect());
  endtask

  task automatic chk_reset_words(input string tag, input logic [1:0] st);
    chk({tag, "_pipe_1"}, bus.pipe_1, 32'h08CA00C8);
    chk({tag, "_pipe_2"}, bus.pipe_2, 32'h08CA00A0);
    chk({tag, "_pipe_3"}, bus.pipe_3, 32'h08CA00F0);
    chk({tag, "_coin"},   bus.coin,   32'h0);
    chk({tag, "_score"},  32'(bus.score), 32'h0);
    chk({tag, "_state"},  32'(bus.state), 32'(st));
  endtask

  function automatic bit about_to_pass();
    for (int i = 0; i < 3; i++)
      if (m_pos[i] > -10 && m_pos[i] - 2 <= -10) return 1;
    return 0;
  endfunction

  // Monitor: one expected entry per clock, compared just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pipe_1", bus.pipe_1, e.p1);
        chk("pipe_2", bus.pipe_2, e.p2);
        chk("pipe_3", bus.pipe_3, e.p3);
        chk("coin", bus.coin, e.coin);
        chk("score", 32'(bus.score), 32'(e.score));
        chk("pass_pulse", 32'(bus.pass_pulse), 32'(e.pass));
        chk("state", 32'(bus.state), 32'(e.st));
      end
    end
  end

  initial begin
    logic s, h, t, ch;
    clrn           = 1'b0;
    bus.start      = 1'b0;
    bus.hit        = 1'b0;
    bus.frame_tick = 1'b0;
    bus.coin_hit   = 1'b0;
    m_reset();

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk_reset_words("reset", 2'b00);

    // Directed scroll from start: tick every cycle through the first pass and respawn.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 345; n++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (n == 20 || n == 324 || n == 325 || n == 326 || n == 345) begin
        @(posedge clk); #2;
        if (n == 20) begin
          chk("t20_pipe1_x", 32'(bus.pipe_1[19:10]), 32'd600);
          chk("t20_pipe2_x", 32'(bus.pipe_2[19:10]), 32'd640);
          chk("t20_state", 32'(bus.state), 32'd1);
        end
        if (n == 324) chk("t324_pass", 32'(bus.pass_pulse), 32'd0);
        if (n == 325) begin
          chk("t325_pass", 32'(bus.pass_pulse), 32'd1);
          chk("t325_score", 32'(bus.score), 32'h0001);
        end
        if (n == 326) chk("t326_pass", 32'(bus.pass_pulse), 32'd0);
        if (n == 345) begin
          chk("t345_x_parked", 32'(bus.pipe_1[19:10]), 32'd640);
          chk("t345_h_range", 32'(bus.pipe_1[9:0] >= 10'd80 && bus.pipe_1[9:0] <= 10'd335), 32'd1);
          chk("t345_gap_range", 32'(bus.pipe_1[27:20] >= 8'd120 && bus.pipe_1[27:20] <= 8'd176), 32'd1);
          chk("t345_gap_step", 32'(bus.pipe_1[22:20]), 32'd0);
        end
      end
    end

    // Freeze holds everything, then start returns to the reset world in RUN.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk_reset_words("restart", 2'b01);

    // Randomised play, with coin pickups steered onto pass ticks whenever possible.
    for (int c = 0; c < 9000; c++) begin
      if (c == 4500) begin
        @(posedge clk); #3;
        clrn = 1'b0;
        #1;
        chk_reset_words("async_rst", 2'b00);
        chk("async_rst_pass", 32'(bus.pass_pulse), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      s  = 1'b0;
      h  = 1'b0;
      t  = ($urandom_range(0, 99) < 60);
      ch = ($urandom_range(0, 99) < 1);
      if (m_state != 1 && $urandom_range(0, 99) < 3) s = 1'b1;
      if (m_state == 1 && $urandom_range(0, 999) < 2) h = 1'b1;
      if (m_state == 1 && $urandom_range(0, 1999) < 1) s = 1'b1;
      if (m_state == 1 && m_act && about_to_pass() && $urandom_range(0, 1) == 1) begin
        s  = 1'b0;
        h  = 1'b0;
        t  = 1'b1;
        ch = 1'b1;
      end
      cyc(1'b1, s, h, t, ch);
    end

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
